// File: rtl/caesar_pkg.sv
// Shared definitions for the Caesar encrypt/decrypt datapaths: symbol/key widths,
// output-buffer state encoding and the mod-26 arithmetic helpers.
package caesar_pkg;

  localparam int ALPHA_SIZE = 26;
  localparam int SYM_W      = 6;
  localparam int KEY_W      = 5;
  localparam int CNT_W      = 8;
  localparam int BUF_W      = SYM_W + 1;  // {err, symbol}

  localparam logic [SYM_W-1:0] SYM_MAX = SYM_W'(ALPHA_SIZE - 1);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  function automatic logic sym_illegal(input logic [SYM_W-1:0] sym);
    return sym > SYM_MAX;
  endfunction

  function automatic logic [KEY_W-1:0] key_reduce(input logic [KEY_W-1:0] k);
    return (k >= KEY_W'(ALPHA_SIZE)) ? k - KEY_W'(ALPHA_SIZE) : k;
  endfunction

  // Both helpers assume a reduced key (0..25); illegal symbols pass through untouched.
  function automatic logic [SYM_W-1:0] mod26_sub(input logic [SYM_W-1:0] sym,
                                                 input logic [KEY_W-1:0] k);
    logic [SYM_W-1:0] kx;
    kx = SYM_W'(k);
    if (sym_illegal(sym)) return sym;
    if (sym >= kx) return sym - kx;
    return sym + SYM_W'(ALPHA_SIZE) - kx;
  endfunction

  function automatic logic [SYM_W-1:0] mod26_add(input logic [SYM_W-1:0] sym,
                                                 input logic [KEY_W-1:0] k);
    logic [SYM_W-1:0] sum;
    sum = sym + SYM_W'(k);
    if (sym_illegal(sym)) return sym;
    return (sum >= SYM_W'(ALPHA_SIZE)) ? sum - SYM_W'(ALPHA_SIZE) : sum;
  endfunction

endpackage

// File: rtl/caesar_skid_buf.sv
// Two-entry registered FIFO. Occupancy is published as `state`; the parent derives
// ready (state != FULL) and valid (state != EMPTY) from it, so both are register-driven.
module caesar_skid_buf
  import caesar_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [BUF_W-1:0] in_data,
  input  logic             out_ready,
  output logic [BUF_W-1:0] out_data,
  output buf_state_e       state
);

  // Handshake: a word enters when in_valid && state != FULL, and leaves when
  // out_ready && state != EMPTY; head holds steady until it leaves.
  buf_state_e       state_next;
  logic             push, pop;
  logic             load_head, shift_head, load_tail;
  logic [BUF_W-1:0] head, tail;

  assign push = in_valid && (state != BUF_FULL);
  assign pop  = out_ready && (state != BUF_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BUF_EMPTY: if (push) state_next = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_next = BUF_FULL;
        else if (!push && pop) state_next = BUF_EMPTY;
      end
      BUF_FULL:  if (pop) state_next = BUF_ONE;
      default:   state_next = BUF_EMPTY;
    endcase
  end

  always_comb begin
    load_head  = 1'b0;
    shift_head = 1'b0;
    load_tail  = 1'b0;
    case (state)
      BUF_EMPTY: load_head = push;
      BUF_ONE: begin
        load_head = push && pop;
        load_tail = push && !pop;
      end
      BUF_FULL:  shift_head = pop;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head)       head <= in_data;
      else if (shift_head) head <= tail;
      if (load_tail)       tail <= in_data;
    end
  end

  assign out_data = head;

endmodule

// File: rtl/caesar_decrypt_stream.sv
// Caesar receive path: subtracts the latched key mod 26 at acceptance and hands
// {err, plain} to a 2-entry buffer; also counts delivered symbols.
module caesar_decrypt_stream
  import caesar_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             key_load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_cipher,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_plain,
  output logic             out_err,
  output logic             key_err,
  output logic [CNT_W-1:0] sym_count
);

  logic [KEY_W-1:0] key_q;
  logic [BUF_W-1:0] buf_in, buf_out;
  buf_state_e       buf_state;
  logic             out_xfer;

  // A symbol accepted alongside key_load still sees the old key_q here.
  assign buf_in = {sym_illegal(in_cipher), mod26_sub(in_cipher, key_q)};

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      key_q   <= '0;
      key_err <= 1'b0;
    end else if (key_load) begin
      key_q   <= key_reduce(key);
      key_err <= (key >= KEY_W'(ALPHA_SIZE));
    end
  end

  caesar_skid_buf u_buf (
    .clk       (CLOCK_50),
    .rst_n     (rst),
    .in_valid  (in_valid),
    .in_data   (buf_in),
    .out_ready (out_ready),
    .out_data  (buf_out),
    .state     (buf_state)
  );

  assign in_ready  = (buf_state != BUF_FULL);
  assign out_valid = (buf_state != BUF_EMPTY);
  assign out_err   = buf_out[SYM_W];
  assign out_plain = buf_out[SYM_W-1:0];
  assign out_xfer  = out_valid && out_ready;

  // key_load wins over a simultaneous delivery so the count restarts at 0.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst)          sym_count <= '0;
    else if (key_load) sym_count <= '0;
    else if (out_xfer) sym_count <= sym_count + 1'b1;
  end

endmodule

// File: tb/tb_caesar_decrypt_stream.sv
// Directed bench for caesar_decrypt_stream: hand-computed vectors plus a
// 26x26 encrypt/decrypt round trip through the DUT.
module tb_caesar_decrypt_stream;
  import caesar_pkg::*;

  logic             CLOCK_50 = 1'b0;
  logic             rst;
  logic [KEY_W-1:0] key;
  logic             key_load;
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_cipher;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_plain;
  logic             out_err;
  logic             key_err;
  logic [CNT_W-1:0] sym_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SYM_W-1:0] exp_q[$];

  caesar_decrypt_stream dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .key       (key),
    .key_load  (key_load),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cipher (in_cipher),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_plain (out_plain),
    .out_err   (out_err),
    .key_err   (key_err),
    .sym_count (sym_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k);
    key      = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; key = '0; key_load = 1'b0;
    in_valid = 1'b0; in_cipher = '0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_plain", out_plain, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_sym_count", sym_count, 0);
    #11 rst = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // 1: key 3, stream 0,1,2,25 -> 23,24,25,22, one cycle latency
    tick();
    load_key(5'd3);
    out_ready = 1'b1;
    in_valid = 1'b1; in_cipher = 6'd0;  tick(); chk("t1_v0", out_valid, 1); chk("t1_p0", out_plain, 23);
    in_cipher = 6'd1;  tick(); chk("t1_p1", out_plain, 24);
    in_cipher = 6'd2;  tick(); chk("t1_p2", out_plain, 25);
    in_cipher = 6'd25; tick(); chk("t1_p3", out_plain, 22); chk("t1_err", out_err, 0);
    in_valid = 1'b0;   tick(); chk("t1_drained", out_valid, 0); chk("t1_count", sym_count, 4);

    // 2: oversize key 28 -> key_err, effective key 2
    load_key(5'd28);
    chk("t2_key_err", key_err, 1);
    chk("t2_count_clr", sym_count, 0);
    in_valid = 1'b1; in_cipher = 6'd1; tick(); chk("t2_plain", out_plain, 25);
    in_valid = 1'b0; tick();
    load_key(5'd5);
    chk("t2_key_err_clr", key_err, 0);

    // 3: back-pressure with key 5: exactly two accepted, head stable
    out_ready = 1'b0;
    in_valid = 1'b1; in_cipher = 6'd7; tick();
    chk("t3_p_a", out_plain, 2); chk("t3_rdy_a", in_ready, 1);
    in_cipher = 6'd8; tick();
    chk("t3_p_b", out_plain, 2); chk("t3_rdy_b", in_ready, 0);
    in_cipher = 6'd9; tick();
    chk("t3_p_c", out_plain, 2); chk("t3_rdy_c", in_ready, 0); chk("t3_count_hold", sym_count, 0);
    out_ready = 1'b1; tick();
    chk("t3_p_d", out_plain, 3); chk("t3_rdy_d", in_ready, 1);
    tick();
    chk("t3_p_e", out_plain, 4);
    in_valid = 1'b0; tick();
    chk("t3_empty", out_valid, 0); chk("t3_count", sym_count, 3);

    // 4: symbol accepted with key_load uses the old key
    load_key(5'd4);
    in_valid = 1'b1; in_cipher = 6'd10; key = 5'd7; key_load = 1'b1; tick();
    key_load = 1'b0; chk("t4_old_key", out_plain, 6);
    tick(); chk("t4_new_key", out_plain, 3); chk("t4_count", sym_count, 1);
    in_valid = 1'b0; key_load = 1'b1; tick();
    key_load = 1'b0;
    chk("t4_count_load_xfer", sym_count, 0); chk("t4_empty", out_valid, 0);

    // 5: illegal symbol passes through flagged
    load_key(5'd4);
    in_valid = 1'b1; in_cipher = 6'd30; tick();
    chk("t5_bad_plain", out_plain, 30); chk("t5_bad_err", out_err, 1);
    in_cipher = 6'd4; tick();
    chk("t5_ok_plain", out_plain, 0); chk("t5_ok_err", out_err, 0);
    in_valid = 1'b0; tick();

    // 6: async reset with two symbols buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_cipher = 6'd5; tick();
    in_cipher = 6'd6; tick();
    in_valid = 1'b0;
    chk("t6_full", in_ready, 0); chk("t6_pre_count", sym_count, 2);
    #2 rst = 1'b0;
    #1 chk("t6_async_valid", out_valid, 0); chk("t6_async_count", sym_count, 0);
    #3 rst = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_cipher = 6'd9; tick();
    chk("t6_identity", out_plain, 9);
    in_valid = 1'b0; tick();

    // Round trip: encrypt with (s+k)%26, decrypt through the DUT
    for (int k = 0; k < ALPHA_SIZE; k++) begin
      load_key(KEY_W'(k));
      for (int s = 0; s < ALPHA_SIZE; s++) begin
        chk("rt_add", mod26_add(SYM_W'(s), KEY_W'(k)), (s + k) % ALPHA_SIZE);
        in_valid = 1'b1;
        in_cipher = SYM_W'((s + k) % ALPHA_SIZE);
        exp_q.push_back(SYM_W'(s));
        tick();
        chk("rt_valid", out_valid, 1);
        if (exp_q.size() > 0) chk("rt_plain", out_plain, exp_q.pop_front());
      end
      in_valid = 1'b0;
    end
    tick();
    chk("rt_drained", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
